// File: rtl/stage_if_pkg.sv
// Shared CPU fetch definitions: FSM encoding, boot/exception constants and an
// alignment helper used by the instruction-fetch stage.
package stage_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_DEF      = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/stage_if_if.sv
// Single-outstanding-request instruction bus between the fetch stage (master)
// and the instruction memory (slave).
interface stage_if_if;
  logic [31:0] ibusAddr;
  logic        ibusReq;
  logic        ibusAck;
  logic [31:0] ibusData;

  modport master (output ibusAddr, output ibusReq, input ibusAck, input ibusData);
  modport slave  (input ibusAddr, input ibusReq, output ibusAck, output ibusData);
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction bus and
// presents each fetched word (or NOP) with its PC to decode.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP      = NOP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirectPC,
  input  logic [31:0]       nextPC,
  stage_if_if.master        ibus,
  output logic [31:0]       instOut,
  output logic [31:0]       PCOut,
  output logic              adel,
  output logic              fetchWait
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic         aligned;
  logic         word_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      buf_q       <= 32'h0;
      drop_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    drop_addr_d   = drop_addr_q;
    ibus.ibusReq  = 1'b0;
    ibus.ibusAddr = pc_q;
    instOut       = NOP;
    PCOut         = pc_q;
    adel          = 1'b0;
    fetchWait     = 1'b0;
    aligned       = word_aligned(pc_q);
    word_ok       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        fetchWait = 1'b1;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // A misaligned PC never reaches the bus; it completes at once as an AdEL.
        ibus.ibusReq = aligned;
        adel         = ~aligned;
        word_ok      = ~aligned | ibus.ibusAck;
        fetchWait    = ~word_ok;
        // Data acked in a redirect cycle belongs to the flushed path.
        if (aligned && ibus.ibusAck && !redirect) instOut = ibus.ibusData;
        if (redirect) begin
          pc_d = redirectPC;
          if (!word_ok) begin
            drop_addr_d = pc_q;
            state_d     = ST_DROP;
          end
        end else if (word_ok) begin
          if (stall) begin
            buf_d   = aligned ? ibus.ibusData : NOP;
            state_d = ST_HOLD;
          end else begin
            pc_d = nextPC;
          end
        end
      end

      ST_HOLD: begin
        adel    = ~aligned;
        instOut = buf_q;
        if (redirect) begin
          pc_d    = redirectPC;
          buf_d   = NOP;
          state_d = ST_RUN;
        end else if (!stall) begin
          pc_d    = nextPC;
          state_d = ST_RUN;
        end
      end

      ST_DROP: begin
        // Keep the abandoned request stable until the bus completes it.
        ibus.ibusReq  = 1'b1;
        ibus.ibusAddr = drop_addr_q;
        fetchWait     = 1'b1;
        if (redirect) pc_d = redirectPC;
        if (ibus.ibusAck) state_d = ST_RUN;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: stimulus pushes expected decode words into a
// scoreboard queue, a monitor pops them whenever decode accepts a word.
module tb_stage_if;
  import stage_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPC;
  logic [31:0] nextPC;
  logic [31:0] instOut;
  logic [31:0] PCOut;
  logic        adel;
  logic        fetchWait;

  stage_if_if bus ();

  stage_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .nextPC     (nextPC),
    .ibus       (bus),
    .instOut    (instOut),
    .PCOut      (PCOut),
    .adel       (adel),
    .fetchWait  (fetchWait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drv(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic [31:0] npc, input logic ack, input logic [31:0] data);
    stall        = st;
    redirect     = rd;
    redirectPC   = rpc;
    nextPC       = npc;
    bus.ibusAck  = ack;
    bus.ibusData = data;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic a);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.adel = a;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Decode takes a word whenever fetch has one and nothing blocks it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fetchWait === 1'b0 && stall === 1'b0 && redirect === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", instOut);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_inst", instOut, mon_e.inst);
        chk("mon_pc", PCOut, mon_e.pc);
        chk("mon_adel", {31'b0, adel}, {31'b0, mon_e.adel});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.ibusReq}, 32'h0);
    chk("rst_inst", instOut, 32'h0);
    chk("rst_pc", PCOut, 32'hBFC0_0000);
    chk("rst_adel", {31'b0, adel}, 32'h0);
    chk("rst_wait", {31'b0, fetchWait}, 32'h1);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wait", {31'b0, fetchWait}, 32'h1);
    chk("idle_req", {31'b0, bus.ibusReq}, 32'h0);
    next_cycle();

    // zero-wait fetch at the boot vector
    drv(1'b0, 1'b0, 32'h0, 32'hBFC0_0004, 1'b1, 32'h2402_0001);
    push(32'h2402_0001, 32'hBFC0_0000, 1'b0);
    @(negedge clk);
    chk("first_addr", bus.ibusAddr, 32'hBFC0_0000);
    chk("first_req", {31'b0, bus.ibusReq}, 32'h1);
    next_cycle();

    // three wait states on the next fetch
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("wait_addr", bus.ibusAddr, 32'hBFC0_0004);
      chk("wait_flag", {31'b0, fetchWait}, 32'h1);
      chk("wait_inst", instOut, 32'h0);
      next_cycle();
    end
    drv(1'b0, 1'b0, 32'h0, 32'hBFC0_0008, 1'b1, 32'h8C01_0000);
    push(32'h8C01_0000, 32'hBFC0_0004, 1'b0);
    @(negedge clk);
    chk("ack_addr", bus.ibusAddr, 32'hBFC0_0004);
    next_cycle();

    // ack under stall, held two cycles; nextPC must be ignored while stalled
    drv(1'b1, 1'b0, 32'h0, 32'hDEAD_0000, 1'b1, 32'hAAAA_0001);
    @(negedge clk);
    chk("stall_ack_addr", bus.ibusAddr, 32'hBFC0_0008);
    next_cycle();
    drv(1'b1, 1'b0, 32'h0, 32'hDEAD_0004, 1'b0, 32'h0);
    @(negedge clk);
    chk("hold_req", {31'b0, bus.ibusReq}, 32'h0);
    chk("hold_inst", instOut, 32'hAAAA_0001);
    chk("hold_pc", PCOut, 32'hBFC0_0008);
    next_cycle();
    drv(1'b0, 1'b0, 32'h0, 32'hBFC0_0010, 1'b0, 32'h0);
    push(32'hAAAA_0001, 32'hBFC0_0008, 1'b0);
    @(negedge clk);
    chk("release_req", {31'b0, bus.ibusReq}, 32'h0);
    next_cycle();

    // redirect during a two-wait fetch of BFC0_0010
    drv(1'b0, 1'b1, 32'h8000_0180, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("redir_addr", bus.ibusAddr, 32'hBFC0_0010);
    chk("redir_wait", {31'b0, fetchWait}, 32'h1);
    next_cycle();
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("drop_addr", bus.ibusAddr, 32'hBFC0_0010);
    chk("drop_req", {31'b0, bus.ibusReq}, 32'h1);
    chk("drop_inst", instOut, 32'h0);
    next_cycle();
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("drop_ack_addr", bus.ibusAddr, 32'hBFC0_0010);
    chk("drop_ack_wait", {31'b0, fetchWait}, 32'h1);
    chk("drop_ack_inst", instOut, 32'h0);
    next_cycle();
    drv(1'b0, 1'b0, 32'h0, 32'h0040_0002, 1'b1, 32'h0000_0020);
    push(32'h0000_0020, 32'h8000_0180, 1'b0);
    @(negedge clk);
    chk("vector_addr", bus.ibusAddr, 32'h8000_0180);
    next_cycle();

    // misaligned PC
    drv(1'b0, 1'b0, 32'h0, 32'h0040_0000, 1'b1, 32'h5555_5555);
    push(32'h0, 32'h0040_0002, 1'b1);
    @(negedge clk);
    chk("mis_req", {31'b0, bus.ibusReq}, 32'h0);
    chk("mis_adel", {31'b0, adel}, 32'h1);
    chk("mis_wait", {31'b0, fetchWait}, 32'h0);
    next_cycle();

    // redirect with ack and stall in the same cycle
    drv(1'b1, 1'b1, 32'h8000_0200, 32'h0, 1'b1, 32'h1111_1111);
    @(negedge clk);
    chk("redir_ack_addr", bus.ibusAddr, 32'h0040_0000);
    chk("redir_ack_inst", instOut, 32'h0);
    next_cycle();
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("after_redir_addr", bus.ibusAddr, 32'h8000_0200);
    chk("after_redir_req", {31'b0, bus.ibusReq}, 32'h1);

    // asynchronous reset while the request is pending
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus.ibusReq}, 32'h0);
    chk("arst_pc", PCOut, 32'hBFC0_0000);
    chk("arst_wait", {31'b0, fetchWait}, 32'h1);
    chk("arst_inst", instOut, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rearm_idle_wait", {31'b0, fetchWait}, 32'h1);
    next_cycle();
    drv(1'b0, 1'b0, 32'h0, 32'hBFC0_0004, 1'b1, 32'h3C1D_0000);
    push(32'h3C1D_0000, 32'hBFC0_0000, 1'b0);
    @(negedge clk);
    chk("restart_addr", bus.ibusAddr, 32'hBFC0_0000);
    next_cycle();

    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("next_after_restart", bus.ibusAddr, 32'hBFC0_0004);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the five-stage CPU pipeline, directly upstream of the decode stage. Holds the architectural fetch PC, drives a single-outstanding-request instruction bus, and presents each fetched word and its PC to decode. Advances to decode's `nextPC` or to an exception/ERET vector. Absorbs bus wait states by stalling the pipeline, and buffers a word that arrives while decode is stalled.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, PC loaded on reset
- `NOP`, 32'h0000_0000, word presented to decode when no valid instruction exists

Ports:
- `clk`  in  1  pipeline clock
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: decode will not accept this cycle
- `redirect`  in  1  exception/ERET redirect from CP0; highest priority
- `redirectPC`  in  32  target for `redirect`
- `nextPC`  in  32  decode's computed successor PC
- `ibusAddr`  out  32  fetch address
- `ibusReq`  out  1  fetch request; held with stable `ibusAddr` until `ibusAck`
- `ibusAck`  in  1  data valid on `ibusData` this cycle
- `ibusData`  in  32  instruction word
- `instOut`  out  32  instruction to decode (`instIn`)
- `PCOut`  out  32  PC of `instOut` (decode `PC`)
- `adel`  out  1  `PCOut` misaligned; `instOut` forced to `NOP`
- `fetchWait`  out  1  no valid word this cycle; hazard unit must stall

## Operation
- States:
  - IDLE: reset only.
  - RUN: request outstanding for `pc`.
  - HOLD: word captured in `buf`, waiting for `~stall`.
  - DROP: redirect arrived mid-request; discard the ack.
- IDLE -> RUN unconditionally on the first clock after reset.
- RUN:
  - `ibusReq=1`, `ibusAddr=pc`. If `pc[1:0]!=0`: `ibusReq=0`, `adel=1`, word treated as valid immediately.
  - Ack (or misaligned) & `~stall`: `pc<=nextPC`, stay RUN.
  - Ack & `stall`: `buf<=ibusData`, go HOLD.
  - No ack: `fetchWait=1`.
- HOLD:
  - `ibusReq=0`; `instOut=buf`.
  - On `~stall`: `pc<=nextPC`, go RUN.
- DROP:
  - `ibusReq=1`, `ibusAddr=dropAddr` (latched old address); `fetchWait=1`; `instOut=NOP`.
  - On ack: discard data, go RUN.
- `redirect` (any state except IDLE, regardless of `stall`):
  - `pc<=redirectPC`.
  - From RUN without ack: latch `dropAddr<=pc`, go DROP.
  - Otherwise go RUN; `buf` invalidated.
  - During DROP: update `pc`, stay DROP.
- Presentation to decode:
  - RUN: `instOut = ack ? ibusData : NOP` (`NOP` when misaligned); `PCOut=pc`.
  - HOLD: `instOut=buf`; `PCOut=pc`.
  - IDLE/DROP: `instOut=NOP`.
- `fetchWait = (RUN & ~ack & aligned) | DROP | IDLE`.

## Timing
- Reset values: state IDLE, `pc=RESET_PC`, `buf=0`, `dropAddr=0`.
  - Outputs during reset: `ibusReq=0`, `instOut=NOP`, `PCOut=RESET_PC`, `adel=0`, `fetchWait=1`.
- Zero-wait bus (ack in the request cycle): one instruction per cycle; data reaches decode combinationally the same cycle. `pc` updates at the following edge.
- N wait states: `fetchWait` asserted N cycles; `ibusAddr` stable throughout.
- `redirect` and ack in the same cycle: ack data is discarded, never presented; next cycle RUN at `redirectPC`.
- `redirect` and `stall` together: `redirect` wins.
- `nextPC` is sampled only on the advancing edge; it is ignored in HOLD until `stall` drops.
- Reset asserted mid-request: state returns to IDLE immediately; the bus must tolerate `ibusReq` dropping without ack.

## Structure
- Shared CPU package holds: state encoding (2-bit enum), `RESET_PC`, `NOP`, `EXC_VECTOR` constants used by CP0.
- No sub-module required; single always_ff for `pc`/state/`buf`/`dropAddr`, one combinational block for outputs.

## Test plan
- Reset release with zero-wait bus returning 32'h2402_0001 -> first request addr 32'hBFC0_0000 on cycle 1; `instOut`=32'h2402_0001, `PCOut`=BFC0_0000; next addr equals `nextPC`=BFC0_0004.
- Bus ack delayed 3 cycles -> `fetchWait`=1 for 3 cycles, `ibusAddr` constant, `instOut`=NOP until ack.
- Ack while `stall`=1 for 2 cycles -> word held in HOLD, `ibusReq`=0; on release, same word and PC to decode, then fetch `nextPC`.
- `redirect` to 32'h8000_0180 during 2-cycle-wait fetch of 32'hBFC0_0010 -> DROP keeps addr BFC0_0010 until ack, data discarded, next request 32'h8000_0180.
- `nextPC`=32'h0040_0002 -> `ibusReq`=0, `adel`=1, `instOut`=NOP, `PCOut`=0040_0002, `fetchWait`=0.
- `rst_n` pulsed low while a request is pending -> outputs return to reset values asynchronously; fetch restarts at BFC0_0000.
